line_buffer_reader: RTL and testbench



---
 rtl/line_buffer_pkg.sv | 22 ++
 rtl/lbr_fifo.sv | 73 +++++++
 rtl/line_buffer_reader.sv | 185 ++++++++++++++++++
 tb/tb_line_buffer_reader.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_buffer_pkg.sv
// Shared types and elaboration helpers for the line-buffer read sequencer.
package line_buffer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } lbr_state_e;

   localparam int LBR_RD_LAT_MIN = 1;
   localparam int LBR_RD_LAT_MAX = 2;

   function automatic bit lbr_rd_lat_legal(input int lat);
      return (lat >= LBR_RD_LAT_MIN) && (lat <= LBR_RD_LAT_MAX);
   endfunction

   // Width able to hold every value 0..n inclusive.
   function automatic int lbr_cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/lbr_fifo.sv
// Synchronous register FIFO; zero-latency read from flops, flush clears occupancy in one cycle.
// Writes while full are dropped (the caller guarantees this never happens).
module lbr_fifo
   import line_buffer_pkg::*;
#(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4,
   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW   = lbr_cnt_width(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             wr_vld_i,
   input  logic [WIDTH-1:0] wr_dat_i,
   input  logic             rd_rdy_i,
   output logic             rd_vld_o,
   output logic [WIDTH-1:0] rd_dat_o,
   output logic [CW-1:0]    count_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             wr_en, rd_en;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o   = (count_q == CW'(DEPTH));
   assign empty_o  = (count_q == '0);
   assign count_o  = count_q;
   assign rd_vld_o = ~empty_o;
   // Idle output reads as zero so the stream shows clean reset values.
   assign rd_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

   assign wr_en = wr_vld_i & ~full_o;
   assign rd_en = rd_rdy_i & ~empty_o;

   always_comb begin
      rd_ptr_d = rd_en ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      wr_ptr_d = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      count_d  = count_q;
      if (wr_en && !rd_en) begin
         count_d = count_q + 1'b1;
      end else if (!wr_en && rd_en) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= wr_dat_i;
      end
   end

endmodule

// File: rtl/line_buffer_reader.sv
// Line-buffer read sequencer: start -> first RAM read next cycle, data out RD_LAT+1 cycles later; reads are
// credit-limited by FIFO space so m_ready backpressure never drops data. Optional abort port: LINE_BUFFER_READER_ABORT_EN.
module line_buffer_reader
   import line_buffer_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 9,
   parameter int RD_LAT     = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  rclk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   len,
   output logic                  busy,
   output logic                  done,
   output logic                  ram_re,
   output logic [ADDR_WIDTH-1:0] ram_raddr,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last
`ifdef LINE_BUFFER_READER_ABORT_EN
   ,
   input  logic                  abort
`endif
);

   localparam int CW = lbr_cnt_width(FIFO_DEPTH);
   localparam int IW = lbr_cnt_width(RD_LAT);
   localparam int UW = CW + 2;
   localparam int LW = ADDR_WIDTH + 1;

   generate
      if (!lbr_rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
         $error("line_buffer_reader: RD_LAT must be 1 or 2");
      end
      if (FIFO_DEPTH < 2) begin : g_bad_depth
         $error("line_buffer_reader: FIFO_DEPTH must be at least 2");
      end
   endgenerate

   lbr_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LW-1:0]         issue_left_q, issue_left_d;
   logic [LW-1:0]         wr_left_q, wr_left_d;
   logic [RD_LAT-1:0]     sr_q, sr_d;
   logic                  done_q, done_d;

   logic [IW-1:0]         inflight;
   logic [UW-1:0]         used;
   logic                  credit_ok;
   logic                  flush;
   logic                  start_ok;
   logic                  pop;

   logic                  fifo_wr;
   logic                  fifo_wr_last;
   logic [DATA_WIDTH:0]   fifo_rd_dat;
   logic [CW-1:0]         fifo_count;
   logic                  fifo_full;
   logic                  fifo_empty;

`ifdef LINE_BUFFER_READER_ABORT_EN
   assign flush    = abort & (state_q != IDLE);
   assign start_ok = start & ~abort;
`else
   assign flush    = 1'b0;
   assign start_ok = start;
`endif

   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         inflight = inflight + IW'(sr_q[i]);
      end
   end

   // Credit uses only registered occupancy; a pop this cycle frees credit next cycle.
   assign used      = UW'(fifo_count) + UW'(inflight);
   assign credit_ok = (used < UW'(FIFO_DEPTH));

   // Tail of the latency pipe marks the cycle ram_rdata belongs to an issued read.
   assign sr_d         = RD_LAT'({sr_q, ram_re});
   assign fifo_wr      = sr_q[RD_LAT-1];
   assign fifo_wr_last = (wr_left_q == LW'(1));
   assign pop          = m_valid & m_ready;

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      issue_left_d = issue_left_q;
      wr_left_d    = wr_left_q;
      done_d       = 1'b0;
      ram_re       = 1'b0;

      if (fifo_wr) begin
         wr_left_d = wr_left_q - 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (start_ok) begin
               if (len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d      = READ;
                  addr_d       = base_addr;
                  issue_left_d = len;
                  wr_left_d    = len;
               end
            end
         end
         READ: begin
            ram_re = credit_ok;
            if (credit_ok) begin
               addr_d       = addr_q + 1'b1;
               issue_left_d = issue_left_q - 1'b1;
               if (issue_left_q == LW'(1)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (pop && m_last) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (flush) begin
         state_d = IDLE;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge rclk) begin
      if (rst) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         issue_left_q <= '0;
         wr_left_q    <= '0;
         sr_q         <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         issue_left_q <= issue_left_d;
         wr_left_q    <= wr_left_d;
         sr_q         <= flush ? '0 : sr_d;
         done_q       <= done_d;
         if (!flush) begin
            assert (!(fifo_wr && fifo_full));
         end
      end
   end

   lbr_fifo #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i    (rclk),
      .rst_i    (rst),
      .flush_i  (flush),
      .wr_vld_i (fifo_wr),
      .wr_dat_i ({fifo_wr_last, ram_rdata}),
      .rd_rdy_i (m_ready),
      .rd_vld_o (m_valid),
      .rd_dat_o (fifo_rd_dat),
      .count_o  (fifo_count),
      .full_o   (fifo_full),
      .empty_o  (fifo_empty)
   );

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign ram_raddr = addr_q;
   assign m_data    = fifo_rd_dat[DATA_WIDTH-1:0];
   assign m_last    = fifo_rd_dat[DATA_WIDTH] & ~fifo_empty;

endmodule

// File: tb/tb_line_buffer_reader.sv
// Bench for line_buffer_reader: cycle tables for the fixed-timing cases plus a scoreboard-backed protocol monitor.
module tb_line_buffer_reader;

   localparam int DW     = 8;
   localparam int AW     = 9;
   localparam int RD_LAT = 2;
   localparam int DEPTH  = 4;
   localparam int NWORDS = 2 ** AW;

   logic          rclk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   len;
   logic          busy, done, ram_re;
   logic [AW-1:0] ram_raddr;
   logic [DW-1:0] ram_rdata;
   logic [DW-1:0] m_data;
   logic          m_valid, m_ready, m_last;
`ifdef LINE_BUFFER_READER_ABORT_EN
   logic          abort;
`endif

   always #5 rclk = ~rclk;

   line_buffer_reader #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .RD_LAT     (RD_LAT),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .rclk      (rclk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .len       (len),
      .busy      (busy),
      .done      (done),
      .ram_re    (ram_re),
      .ram_raddr (ram_raddr),
      .ram_rdata (ram_rdata),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_last    (m_last)
`ifdef LINE_BUFFER_READER_ABORT_EN
      ,
      .abort     (abort)
`endif
   );

   // RAM read-port model with a fixed RD_LAT pipeline.
   logic [DW-1:0] mem [NWORDS];
   logic [DW-1:0] pipe_q;
   always @(posedge rclk) begin
      if (RD_LAT == 1) begin
         ram_rdata <= mem[ram_raddr];
      end else begin
         pipe_q    <= mem[ram_raddr];
         ram_rdata <= pipe_q;
      end
   end

   typedef struct packed {
      logic [DW-1:0] d;
      logic          l;
   } word_t;

   typedef struct {
      bit            start;
      logic [AW-1:0] base;
      logic [AW:0]   len;
      bit            busy, re, vld, last, done;
   } vec_t;

   int      tests = 0;
   int      fails = 0;
   bit      run_active, exp_done, prev_stall;
   int      run_len, issued, outstanding, hs_count;
   logic [AW-1:0] run_base;
   logic [DW-1:0] prev_d;
   logic          prev_l;
   word_t   sb[$];
   logic [AW-1:0] addr_log[$];

   task automatic chk(input string nm, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Protocol monitor: compares this cycle's outputs to the model, then advances the model.
   task automatic monitor();
      bit    exp_re, hs, got_last, was_active, abort_hit;
      word_t w;
      exp_re   = run_active && (issued < run_len) && (outstanding < DEPTH);
      hs       = m_valid && m_ready;
      got_last = 1'b0;
      chk("busy", busy, run_active);
      chk("done", done, exp_done);
      chk("ram_re", ram_re, exp_re);
      if (ram_re && exp_re) begin
         chk("raddr", ram_raddr, (int'(run_base) + issued) % NWORDS);
         addr_log.push_back(ram_raddr);
      end
      if (prev_stall) begin
         chk("hold_valid", m_valid, 1);
         chk("hold_data", m_data, prev_d);
         chk("hold_last", m_last, prev_l);
      end
      if (hs) begin
         hs_count++;
         if (sb.size() == 0) begin
            chk("extra_word", 1, 0);
         end else begin
            w = sb.pop_front();
            chk("m_data", m_data, w.d);
            chk("m_last", m_last, w.l);
            got_last = w.l;
         end
      end
      prev_stall = m_valid && !m_ready;
      prev_d     = m_data;
      prev_l     = m_last;
`ifdef LINE_BUFFER_READER_ABORT_EN
      abort_hit = abort;
`else
      abort_hit = 1'b0;
`endif
      if (rst || (abort_hit && run_active)) begin
         run_active  = 1'b0;
         exp_done    = 1'b0;
         issued      = 0;
         outstanding = 0;
         prev_stall  = 1'b0;
         sb.delete();
      end else begin
         was_active = run_active;
         exp_done   = 1'b0;
         if (ram_re) begin
            issued++;
            outstanding++;
         end
         if (hs) outstanding--;
         if (hs && got_last) begin
            run_active = 1'b0;
            exp_done   = 1'b1;
         end
         if (!was_active && start && !abort_hit) begin
            if (len == 0) begin
               exp_done = 1'b1;
            end else begin
               run_active = 1'b1;
               run_len    = int'(len);
               run_base   = base_addr;
               issued     = 0;
               for (int i = 0; i < int'(len); i++) begin
                  sb.push_back({mem[(int'(base_addr) + i) % NWORDS], (i == int'(len) - 1)});
               end
            end
         end
      end
   endtask

   task automatic cycle();
      @(negedge rclk);
      monitor();
      @(posedge rclk);
      #1;
   endtask

   task automatic cycle_quiet(input string nm, input bit full_reset);
      @(negedge rclk);
      monitor();
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_done"}, done, 0);
      chk({nm, "_ram_re"}, ram_re, 0);
      chk({nm, "_m_valid"}, m_valid, 0);
      if (full_reset) begin
         chk({nm, "_raddr"}, ram_raddr, 0);
         chk({nm, "_m_data"}, m_data, 0);
         chk({nm, "_m_last"}, m_last, 0);
      end
      @(posedge rclk);
      #1;
   endtask

   task automatic start_run(input logic [AW-1:0] b, input int n);
      start     = 1'b1;
      base_addr = b;
      len       = (AW + 1)'(n);
      cycle();
      start = 1'b0;
   endtask

   task automatic wait_idle(input string nm, input int budget);
      int n = 0;
      while ((run_active || exp_done || sb.size() != 0) && n < budget) begin
         cycle();
         n++;
      end
      tests++;
      if (run_active || exp_done || sb.size() != 0) begin
         fails++;
         $display("FAIL %s_timeout: still busy after %0d cycles, %0d words pending", nm, budget, sb.size());
      end
   endtask

   vec_t          vecs[17];
   logic [AW-1:0] wrap_exp[4];

   initial begin
      for (int i = 0; i < NWORDS; i++) mem[i] = DW'(i * 13 + (i >> 8) * 101 + 5);
      for (int c = 0; c < 14; c++) begin
         vecs[c].start = (c == 0);
         vecs[c].base  = 9'h010;
         vecs[c].len   = 10'd8;
         vecs[c].busy  = (c >= 1 && c <= 11);
         vecs[c].re    = (c >= 1 && c <= 8);
         vecs[c].vld   = (c >= 4 && c <= 11);
         vecs[c].last  = (c == 11);
         vecs[c].done  = (c == 12);
      end
      for (int c = 14; c < 17; c++) begin
         vecs[c].start = (c == 14);
         vecs[c].base  = 9'h033;
         vecs[c].len   = 10'd0;
         vecs[c].busy  = 1'b0;
         vecs[c].re    = 1'b0;
         vecs[c].vld   = 1'b0;
         vecs[c].last  = 1'b0;
         vecs[c].done  = (c == 15);
      end
      wrap_exp[0] = 9'h1FE;
      wrap_exp[1] = 9'h1FF;
      wrap_exp[2] = 9'h000;
      wrap_exp[3] = 9'h001;

      rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b1;
`ifdef LINE_BUFFER_READER_ABORT_EN
      abort = 1'b0;
`endif
      run_active = 0; exp_done = 0; prev_stall = 0;
      issued = 0; outstanding = 0; hs_count = 0; run_len = 0; run_base = '0;
      @(posedge rclk);
      #1;
      cycle();
      cycle_quiet("reset", 1'b1);
      rst = 1'b0;
      cycle();

      // Exact-timing tables: len=8 at 0x010, then len=0.
      for (int i = 0; i < 17; i++) begin
         start     = vecs[i].start;
         base_addr = vecs[i].base;
         len       = vecs[i].len;
         @(negedge rclk);
         monitor();
         chk($sformatf("tbl%0d_busy", i), busy, vecs[i].busy);
         chk($sformatf("tbl%0d_ram_re", i), ram_re, vecs[i].re);
         chk($sformatf("tbl%0d_m_valid", i), m_valid, vecs[i].vld);
         chk($sformatf("tbl%0d_m_last", i), m_last, vecs[i].last);
         chk($sformatf("tbl%0d_done", i), done, vecs[i].done);
         @(posedge rclk);
         #1;
      end
      start = 1'b0;
      cycle();

      // Address wrap-around.
      addr_log.delete();
      start_run(9'h1FE, 4);
      wait_idle("wrap", 40);
      chk("wrap_count", addr_log.size(), 4);
      for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
         chk($sformatf("wrap_addr%0d", i), addr_log[i], wrap_exp[i]);
      end

      // Credit stall followed by random backpressure.
      hs_count = 0;
      m_ready  = 1'b0;
      start_run(9'h080, 16);
      for (int i = 0; i < 8; i++) cycle();
      chk("credit_stop_issued", issued, DEPTH);
      for (int i = 0; i < 300 && (run_active || sb.size() != 0); i++) begin
         m_ready = 1'($urandom_range(0, 1));
         cycle();
      end
      m_ready = 1'b1;
      wait_idle("random_ready", 40);
      chk("random_ready_words", hs_count, 16);

      // Start while busy is ignored.
      hs_count = 0;
      start_run(9'h020, 6);
      cycle();
      cycle();
      start_run(9'h100, 9);
      wait_idle("ignored_start", 60);
      chk("ignored_start_words", hs_count, 6);

      // Reset in cycle 6 of a len=32 run.
      start_run(9'h040, 32);
      for (int i = 1; i < 6; i++) cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      cycle_quiet("midrst", 1'b1);
      hs_count = 0;
      start_run(9'h150, 5);
      wait_idle("post_reset", 60);
      chk("post_reset_words", hs_count, 5);

`ifdef LINE_BUFFER_READER_ABORT_EN
      // Abort in cycle 5 of a len=20 run, then a clean len=3 run.
      start_run(9'h0A0, 20);
      for (int i = 1; i < 5; i++) cycle();
      abort = 1'b1;
      cycle();
      abort = 1'b0;
      cycle_quiet("abort", 1'b0);
      for (int i = 0; i < 4; i++) cycle();
      hs_count = 0;
      start_run(9'h0C0, 3);
      wait_idle("post_abort", 40);
      chk("post_abort_words", hs_count, 3);
`endif

      cycle();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
